// File: rtl/display_scan_if.sv
// display_scan_if: data/control inputs and pin-side outputs of the 7-segment scan driver
interface display_scan_if #(
    parameter int N_DIGITS = 8,
    parameter int BRIGHT_W = 3
);
    logic [4*N_DIGITS-1:0]       digs;
    logic [N_DIGITS-1:0]         an_on;
    logic [N_DIGITS-1:0]         dp_in;
    logic [BRIGHT_W-1:0]         brightness;
    logic                        blank_lz;
    logic [3:0]                  disp;
    logic                        dp_n;
    logic [N_DIGITS-1:0]         an;
    logic [$clog2(N_DIGITS)-1:0] digit_idx;
    logic                        frame_tick;
    modport master (
        output digs, an_on, dp_in, brightness, blank_lz,
        input  disp, dp_n, an, digit_idx, frame_tick
    );
    modport slave (
        input  digs, an_on, dp_in, brightness, blank_lz,
        output disp, dp_n, an, digit_idx, frame_tick
    );
endinterface

// File: rtl/display_scan_driver.sv
// display_scan_driver: self-timed multiplexed 7-segment scan with PWM, LZ blanking and frame snapshots
module display_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 3
) (
    input logic           clk,
    input logic           reset,
    display_scan_if.slave bus
);
    localparam int IW  = $clog2(N_DIGITS);
    localparam int PW  = $clog2(REFRESH_DIV);
    localparam int SUB = REFRESH_DIV >> BRIGHT_W;
    logic [PW-1:0]         pcnt, sp;
    logic [IW-1:0]         slot;
    logic                  primed, s_blz, z, pwrap, fwrap, light;
    logic [4*N_DIGITS-1:0] s_digs;
    logic [N_DIGITS-1:0]   s_an_on, s_dp, lz;
    logic [BRIGHT_W-1:0]   s_bright;
    logic [3:0]            nib;
    // A digit is blanked while it and every more significant nibble are zero; digit 0 always shows
    always_comb begin
        lz = '0;
        z  = s_blz;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            z     = z && (s_digs[4*k +: 4] == 4'd0);
            lz[k] = z;
        end
        nib   = s_digs[{slot, 2'b00} +: 4];
        sp    = pcnt / PW'(SUB);
        pwrap = pcnt == PW'(REFRESH_DIV - 1);
        fwrap = pwrap && (slot == IW'(N_DIGITS - 1));
        light = (pcnt != '0) && (sp <= PW'(s_bright)) && s_an_on[slot] && !lz[slot];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt           <= '0;
            slot           <= '0;
            primed         <= 1'b0;
            s_digs         <= '0;
            s_an_on        <= '0;
            s_dp           <= '0;
            s_bright       <= '0;
            s_blz          <= 1'b0;
            bus.an         <= '1;
            bus.disp       <= 4'd0;
            bus.dp_n       <= 1'b1;
            bus.digit_idx  <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            pcnt   <= pwrap ? '0 : pcnt + 1'b1;
            slot   <= !pwrap ? slot : (slot == IW'(N_DIGITS - 1)) ? '0 : slot + 1'b1;
            primed <= 1'b1;
            // Inputs only take effect at frame boundaries so a frame never mixes two values
            if (!primed || fwrap) begin
                s_digs   <= bus.digs;
                s_an_on  <= bus.an_on;
                s_dp     <= bus.dp_in;
                s_bright <= bus.brightness;
                s_blz    <= bus.blank_lz;
            end
            bus.an         <= ~(N_DIGITS'(light) << slot);
            bus.disp       <= nib;
            bus.dp_n       <= ~(s_dp[slot] && light);
            bus.digit_idx  <= slot;
            bus.frame_tick <= fwrap;
        end
    end
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: scoreboard-checked directed bench for the scan driver (4 digits, 8-cycle slots)
module tb_display_scan_driver;
    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BW = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    display_scan_if #(.N_DIGITS(N), .BRIGHT_W(BW)) bus();
    display_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .BRIGHT_W(BW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [3:0] an;
        logic [3:0] disp;
        logic       dp_n;
        logic [1:0] idx;
        logic       ft;
    } exp_t;
    exp_t sb[$];
    int m_p;
    logic [15:0] m_digs;
    logic [3:0] m_on, m_dp;
    logic [1:0] m_br;
    logic m_blz;
    // Expected outputs after the p-th clock edge since reset release, from the frozen frame inputs
    function automatic exp_t expect_out(input int p);
        int pc, sl;
        logic lzb, lit;
        exp_t e;
        pc = p % RD;
        sl = (p / RD) % N;
        lzb = m_blz && (sl > 0) && ((m_digs >> (4 * sl)) == 16'd0);
        lit = (pc != 0) && ((pc / (RD >> BW)) <= int'(m_br)) && m_on[sl] && !lzb;
        e.an = lit ? ~(4'b0001 << sl) : 4'hF;
        e.disp = m_digs[4*sl +: 4];
        e.dp_n = !(m_dp[sl] && lit);
        e.idx = sl[1:0];
        e.ft = (p % (RD * N)) == (RD * N - 1);
        return e;
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_p <= 0;
            m_digs <= '0;
            m_on <= '0;
            m_dp <= '0;
            m_br <= '0;
            m_blz <= 1'b0;
            sb.delete();
        end else begin
            sb.push_back(expect_out(m_p));
            if (m_p == 0 || (m_p % (RD * N)) == (RD * N - 1)) begin
                m_digs <= bus.digs;
                m_on <= bus.an_on;
                m_dp <= bus.dp_in;
                m_br <= bus.brightness;
                m_blz <= bus.blank_lz;
            end
            m_p <= m_p + 1;
        end
    end
    always @(negedge clk) begin
        if (!reset && sb.size() > 0) begin
            n_tests++;
            assert ({bus.an, bus.disp, bus.dp_n, bus.digit_idx, bus.frame_tick} === sb[0]) else begin
                n_fail++;
                $error("FAIL scan p=%0d observed=%h expected=%h", m_p - 1,
                       {bus.an, bus.disp, bus.dp_n, bus.digit_idx, bus.frame_tick}, sb[0]);
            end
            void'(sb.pop_front());
        end
    end
    task automatic chk(input string tag, input int obs, input int want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask
    // Counts anode-on cycles over the full frame following the next frame_tick
    task automatic lit_count(input string tag, input int want);
        int w, cnt;
        w = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.frame_tick && w < 40);
        chk({tag, "_tick"}, int'(bus.frame_tick), 1);
        repeat (RD * N) begin
            @(negedge clk);
            if (bus.an != 4'hF) cnt++;
        end
        chk(tag, cnt, want);
    endtask
    initial begin
        int w;
        bus.digs = 16'h4321;
        bus.an_on = 4'hF;
        bus.dp_in = 4'h0;
        bus.brightness = 2'd3;
        bus.blank_lz = 1'b0;
        run(3);
        chk("rst_an", int'(bus.an), 15);
        chk("rst_disp", int'(bus.disp), 0);
        chk("rst_dp_n", int'(bus.dp_n), 1);
        chk("rst_idx", int'(bus.digit_idx), 0);
        chk("rst_ft", int'(bus.frame_tick), 0);
        reset = 1'b0;
        run(40);
        lit_count("lit_b3", 28);
        w = 0;
        while (bus.digit_idx != 2'd2 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("reach_slot2", int'(bus.digit_idx), 2);
        run(3);
        #2 reset = 1'b1;
        #1;
        chk("midrst_an", int'(bus.an), 15);
        chk("midrst_dp_n", int'(bus.dp_n), 1);
        chk("midrst_disp", int'(bus.disp), 0);
        chk("midrst_idx", int'(bus.digit_idx), 0);
        @(negedge clk);
        reset = 1'b0;
        run(40);
        bus.brightness = 2'd0;
        lit_count("lit_b0", 4);
        bus.brightness = 2'd1;
        lit_count("lit_b1", 12);
        bus.brightness = 2'd3;
        bus.digs = 16'h0050;
        bus.blank_lz = 1'b1;
        lit_count("lz_0050", 14);
        bus.digs = 16'h0000;
        lit_count("lz_zero", 7);
        bus.blank_lz = 1'b0;
        bus.digs = 16'h1111;
        lit_count("coh_1111", 28);
        run(10);
        chk("coh_slot1", int'(bus.digit_idx), 1);
        bus.digs = 16'h2222;
        run(70);
        bus.dp_in = 4'b0100;
        bus.an_on = 4'b1011;
        lit_count("dp_en", 21);
        run(40);
        bus.an_on = 4'hF;
        run(70);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
